// File: rtl/multicycle_mem_responder_pkg.sv
// multicycle_mem_responder_pkg: shared state/op encodings and widths for the memory responder
package multicycle_mem_responder_pkg;
  localparam int DATA_W = 32;
  localparam int CNT_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;
endpackage

// File: rtl/multicycle_mem_responder_if.sv
// multicycle_mem_responder_if: request/response bus between the control unit and the memory responder
interface multicycle_mem_responder_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] addr;
  logic [31:0] din;
  logic mem_read;
  logic mem_write;
  logic is_ready;
  logic resp_valid;
  logic [31:0] dout;
  modport master (output addr, din, mem_read, mem_write, input is_ready, resp_valid, dout);
  modport slave (input addr, din, mem_read, mem_write, output is_ready, resp_valid, dout);
endinterface

// File: rtl/mem_latency_counter.sv
// mem_latency_counter: loadable down-counter that saturates at zero and flags expiry
module mem_latency_counter
  import multicycle_mem_responder_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  output logic             expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_value : (cnt_q != '0 ? cnt_q - 1'b1 : cnt_q);
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign expired = cnt_q == '0;
endmodule

// File: rtl/multicycle_mem_responder.sv
// multicycle_mem_responder: fixed-latency word memory behind a ready/valid request port
module multicycle_mem_responder
  import multicycle_mem_responder_pkg::*;
#(
  parameter int LATENCY   = 4,
  parameter int NUM_WORDS = 16384,
  parameter int ADDR_W    = 32
) (
  input logic clk,
  input logic reset,
  multicycle_mem_responder_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LATENCY > 1 ? LATENCY - 2 : 0);
  state_e state_q, state_d;
  op_e op_q, op_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DATA_W-1:0] din_q, din_d, dout_q, dout_d;
  logic accept, load, expired, enter_done, unused_addr;
  logic [DATA_W-1:0] mem_q [NUM_WORDS];
  mem_latency_counter u_cnt (
    .clk(clk),
    .reset(reset),
    .load(load),
    .load_value(LOAD_VAL),
    .expired(expired)
  );
  // With LATENCY==1 the DONE entry edge is the acceptance edge, so the
  // storage access uses the incoming request rather than the latched one.
  always_comb begin
    accept = state_q == ST_IDLE && (bus.mem_read || bus.mem_write);
    op_d = accept ? (bus.mem_write ? OP_WRITE : OP_READ) : op_q;
    idx_d = accept ? bus.addr[IDX_W+1:2] : idx_q;
    din_d = accept && bus.mem_write ? bus.din : din_q;
    load = accept && LATENCY > 1;
    state_d = accept ? (LATENCY == 1 ? ST_DONE : ST_BUSY)
            : (state_q == ST_BUSY && expired) ? ST_DONE
            : state_q == ST_DONE ? ST_IDLE : state_q;
    enter_done = state_d == ST_DONE && state_q != ST_DONE;
    dout_d = (enter_done && op_d == OP_READ) ? mem_q[idx_d]
           : state_q == ST_DONE ? '0 : dout_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q <= OP_READ;
      idx_q <= '0;
      din_q <= '0;
      dout_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      idx_q <= idx_d;
      din_q <= din_d;
      dout_q <= dout_d;
    end
  end
  always_ff @(posedge clk)
    if (!reset && enter_done && op_d == OP_WRITE) mem_q[idx_d] <= din_d;
  assign unused_addr = ^bus.addr[ADDR_W-1:0];
  assign bus.is_ready = state_q == ST_IDLE;
  assign bus.resp_valid = state_q == ST_DONE;
  assign bus.dout = dout_q;
endmodule

// File: tb/tb_multicycle_mem_responder.sv
// tb_multicycle_mem_responder: directed plus random checks of two responder configurations
module tb_multicycle_mem_responder;
  logic clk = 0;
  logic reset = 1;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] m0 [int];
  logic [31:0] m1 [int];
  always #5 clk = ~clk;
  multicycle_mem_responder_if #(.ADDR_W(32)) bus0 ();
  multicycle_mem_responder_if #(.ADDR_W(32)) bus1 ();
  multicycle_mem_responder #(.LATENCY(4), .NUM_WORDS(16384), .ADDR_W(32)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  multicycle_mem_responder #(.LATENCY(1), .NUM_WORDS(16), .ADDR_W(32)) u1 (.clk(clk), .reset(reset), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_check(input string tag);
    check({tag, " rdy0"}, 32'(bus0.is_ready), 1);
    check({tag, " vld0"}, 32'(bus0.resp_valid), 0);
    check({tag, " dout0"}, bus0.dout, 0);
    check({tag, " rdy1"}, 32'(bus1.is_ready), 1);
    check({tag, " vld1"}, 32'(bus1.resp_valid), 0);
    check({tag, " dout1"}, bus1.dout, 0);
  endtask

  // Called at a negedge with the target idle; returns at the negedge where it is idle again.
  task automatic txn(input int d, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd, input string tag);
    int lat, nw, idx;
    logic [31:0] exp_rd;
    logic rv, rdy;
    logic [31:0] dv;
    lat = d ? 1 : 4;
    nw = d ? 16 : 16384;
    idx = int'((a >> 2) % nw);
    check({tag, " ready before"}, 32'(d ? bus1.is_ready : bus0.is_ready), 1);
    if (d == 0) begin
      bus0.mem_read = rd; bus0.mem_write = wr; bus0.addr = a; bus0.din = wd;
    end else begin
      bus1.mem_read = rd; bus1.mem_write = wr; bus1.addr = a; bus1.din = wd;
    end
    exp_rd = 0;
    if (wr) begin
      if (d) m1[idx] = wd; else m0[idx] = wd;
    end else exp_rd = d ? m1[idx] : m0[idx];
    @(posedge clk);
    #1;
    bus0.mem_read = 0; bus0.mem_write = 0;
    bus1.mem_read = 0; bus1.mem_write = 0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      rv = d ? bus1.resp_valid : bus0.resp_valid;
      rdy = d ? bus1.is_ready : bus0.is_ready;
      dv = d ? bus1.dout : bus0.dout;
      check($sformatf("%s vld c%0d", tag, k), 32'(rv), 32'(k == lat));
      check($sformatf("%s rdy c%0d", tag, k), 32'(rdy), 32'(k == lat + 1));
      check($sformatf("%s dout c%0d", tag, k), dv, k == lat ? exp_rd : 32'h0);
    end
  endtask

  initial begin
    logic [31:0] a;
    int w;
    bus0.mem_read = 0; bus0.mem_write = 0; bus0.addr = 0; bus0.din = 0;
    bus1.mem_read = 0; bus1.mem_write = 0; bus1.addr = 0; bus1.din = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    @(negedge clk);
    idle_check("reset");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle vld0", 32'(bus0.resp_valid), 0);
      check("idle vld1", 32'(bus1.resp_valid), 0);
    end
    txn(0, 0, 1, 32'h0C, 32'hDEADBEEF, "preload3");
    txn(0, 1, 0, 32'h0C, 0, "read3");
    txn(0, 0, 1, 32'h40, 32'h12345678, "wr40");
    txn(0, 1, 0, 32'h43, 0, "rd43");
    txn(0, 1, 1, 32'h08, 32'hA5A5A5A5, "simul");
    txn(0, 1, 0, 32'h08, 0, "rd08");
    txn(0, 0, 1, 32'h20, 32'h1, "old20");
    bus0.mem_write = 1; bus0.addr = 32'h20; bus0.din = 32'hFFFFFFFF;
    @(posedge clk);
    #1 bus0.mem_write = 0;
    @(negedge clk);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    idle_check("midreset");
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post reset vld0", 32'(bus0.resp_valid), 0);
    end
    txn(0, 1, 0, 32'h20, 0, "rd20");
    txn(1, 0, 1, 32'h04, 32'hCAFEF00D, "l1 wr1");
    txn(1, 1, 0, 32'h44, 0, "l1 wrap rd");
    for (int i = 0; i < 40; i++) begin
      w = int'($urandom_range(0, 31));
      a = ($urandom & 32'hFFFF_0003) | (32'(w) << 2);
      if (m0.exists(w) && $urandom_range(0, 1) == 1) txn(0, 1, 0, a, 0, "rnd0 rd");
      else txn(0, $urandom_range(0, 1) == 1, 1, a, $urandom, "rnd0 wr");
    end
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      w = int'((a >> 2) % 16);
      if (m1.exists(w) && $urandom_range(0, 1) == 1) txn(1, 1, 0, a, 0, "rnd1 rd");
      else txn(1, $urandom_range(0, 1) == 1, 1, a, $urandom, "rnd1 wr");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
